// File: rtl/dlx_pipe_ctrl.sv
// dlx_pipe_ctrl: hazard detection, ID operand-a forwarding, fetch flush and
// trap/illegal drain sequencing for the 5-stage DLX pipeline, plus a stall counter.
package dlx_pipe_ctrl_pkg;
    typedef enum logic [2:0] {NOFORW, RR_ALU, IM_ALU, BRANCH, LOAD, STORE} opcode_class;
    typedef logic [4:0] reg_adr;
    typedef enum logic {FWDSEL_ID_A, FWDSEL_EX_MEM_ALU_OUT} fwd_select;
endpackage

module dlx_pipe_ctrl
    import dlx_pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dc_wait,
    input  opcode_class       id_opcode_class,
    input  reg_adr            id_ir_rs1,
    input  reg_adr            id_ir_rs2,
    input  logic              id_cond,
    input  logic              id_halt,
    input  logic              id_illegal_instr,
    input  opcode_class       id_ex_opcode_class,
    input  reg_adr            id_ex_reg_rd,
    input  logic              id_ex_reg_wen,
    input  opcode_class       ex_mem_opcode_class,
    input  reg_adr            ex_mem_reg_rd,
    input  logic              ex_mem_reg_wen,
    output logic              stall,
    output logic              if_hold,
    output logic              if_flush,
    output fwd_select         id_a_fwd_sel,
    output logic              halted,
    output logic              exception,
    output logic [PERF_W-1:0] stall_count
);
    typedef enum logic [2:0] {RUN, HALT_DRAIN, EXC_DRAIN, HALTED, EXC} state_t;

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic       run, use_rs1, use_rs2, rs1_nz, rs2_nz;
    logic       load_use, br_ex, br_ld, haz, trap;

    assign use_rs1 = id_opcode_class inside {RR_ALU, IM_ALU, BRANCH, LOAD, STORE};
    assign use_rs2 = id_opcode_class inside {RR_ALU, STORE};
    assign rs1_nz  = id_ir_rs1 != '0;
    assign rs2_nz  = id_ir_rs2 != '0;

    assign load_use = id_ex_opcode_class == LOAD && id_ex_reg_wen &&
                      ((use_rs1 && rs1_nz && id_ex_reg_rd == id_ir_rs1) ||
                       (use_rs2 && rs2_nz && id_ex_reg_rd == id_ir_rs2));
    // a branch resolves in ID, so it cannot use a result still in EX or a load in MEM
    assign br_ex = id_opcode_class == BRANCH && id_ex_reg_wen && rs1_nz &&
                   id_ex_reg_rd == id_ir_rs1;
    assign br_ld = id_opcode_class == BRANCH && ex_mem_opcode_class == LOAD &&
                   ex_mem_reg_wen && rs1_nz && ex_mem_reg_rd == id_ir_rs1;

    assign run  = rst && state == RUN;
    assign haz  = run && (load_use || br_ex || br_ld);
    assign trap = id_halt || id_illegal_instr;

    // outside RUN (including reset) the front end is frozen and bubbles are issued
    assign stall    = !run || haz || dc_wait || trap;
    assign if_hold  = stall;
    assign if_flush = run && id_cond && !haz && !dc_wait;

    assign id_a_fwd_sel = (rst && ex_mem_reg_wen && rs1_nz && ex_mem_reg_rd == id_ir_rs1 &&
                           ex_mem_opcode_class != LOAD) ? FWDSEL_EX_MEM_ALU_OUT : FWDSEL_ID_A;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (!dc_wait) begin
            case (state)
                RUN: begin
                    if (id_illegal_instr && !haz) begin
                        state_n = EXC_DRAIN;
                        cnt_n   = 3'(DRAIN_CYCLES - 1);
                    end else if (id_halt && !haz) begin
                        state_n = HALT_DRAIN;
                        cnt_n   = 3'(DRAIN_CYCLES - 1);
                    end
                end
                HALT_DRAIN: begin
                    state_n = (cnt == 3'd0) ? HALTED : HALT_DRAIN;
                    cnt_n   = (cnt == 3'd0) ? cnt : cnt - 3'd1;
                end
                EXC_DRAIN: begin
                    state_n = (cnt == 3'd0) ? EXC : EXC_DRAIN;
                    cnt_n   = (cnt == 3'd0) ? cnt : cnt - 3'd1;
                end
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            cnt         <= 3'd0;
            halted      <= 1'b0;
            exception   <= 1'b0;
            stall_count <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            halted    <= halted || state_n == HALTED;
            exception <= exception || state_n == EXC;
            if (run && stall && !(&stall_count))
                stall_count <= stall_count + PERF_W'(1);
        end
    end
endmodule

// File: tb/tb_dlx_pipe_ctrl.sv
// tb_dlx_pipe_ctrl: vector table for the combinational hazard/forward logic,
// hand sequences for drain, freeze, abort-by-reset and counter saturation.
module tb_dlx_pipe_ctrl;
    import dlx_pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dc_wait, id_cond, id_halt, id_illegal_instr;
    logic        id_ex_reg_wen, ex_mem_reg_wen;
    opcode_class id_opcode_class, id_ex_opcode_class, ex_mem_opcode_class;
    reg_adr      id_ir_rs1, id_ir_rs2, id_ex_reg_rd, ex_mem_reg_rd;
    logic        stall, if_hold, if_flush, halted, exception;
    fwd_select   id_a_fwd_sel;
    logic [3:0]  stall_count;

    int n_vec = 0;
    int n_err = 0;

    dlx_pipe_ctrl #(.DRAIN_CYCLES(3), .PERF_W(4)) dut (
        .clk(clk), .rst(rst), .dc_wait(dc_wait),
        .id_opcode_class(id_opcode_class), .id_ir_rs1(id_ir_rs1), .id_ir_rs2(id_ir_rs2),
        .id_cond(id_cond), .id_halt(id_halt), .id_illegal_instr(id_illegal_instr),
        .id_ex_opcode_class(id_ex_opcode_class), .id_ex_reg_rd(id_ex_reg_rd),
        .id_ex_reg_wen(id_ex_reg_wen), .ex_mem_opcode_class(ex_mem_opcode_class),
        .ex_mem_reg_rd(ex_mem_reg_rd), .ex_mem_reg_wen(ex_mem_reg_wen),
        .stall(stall), .if_hold(if_hold), .if_flush(if_flush), .id_a_fwd_sel(id_a_fwd_sel),
        .halted(halted), .exception(exception), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        opcode_class oc;
        reg_adr      rs1, rs2;
        logic        cond, dcw;
        opcode_class exoc;
        reg_adr      exrd;
        logic        exwen;
        opcode_class mmoc;
        reg_adr      mmrd;
        logic        mmwen;
        logic        e_stall, e_flush;
        fwd_select   e_fwd;
    } vec_t;

    typedef struct {
        logic      stall, flush;
        fwd_select fwd;
    } exp_t;

    vec_t tbl[14];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        dc_wait = 0; id_cond = 0; id_halt = 0; id_illegal_instr = 0;
        id_opcode_class = NOFORW; id_ir_rs1 = 0; id_ir_rs2 = 0;
        id_ex_opcode_class = NOFORW; id_ex_reg_rd = 0; id_ex_reg_wen = 0;
        ex_mem_opcode_class = NOFORW; ex_mem_reg_rd = 0; ex_mem_reg_wen = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic drive(input vec_t v);
        id_opcode_class = v.oc; id_ir_rs1 = v.rs1; id_ir_rs2 = v.rs2;
        id_cond = v.cond; dc_wait = v.dcw; id_halt = 0; id_illegal_instr = 0;
        id_ex_opcode_class = v.exoc; id_ex_reg_rd = v.exrd; id_ex_reg_wen = v.exwen;
        ex_mem_opcode_class = v.mmoc; ex_mem_reg_rd = v.mmrd; ex_mem_reg_wen = v.mmwen;
        sb.push_back('{v.e_stall, v.e_flush, v.e_fwd});
    endtask

    task automatic check_out(input int idx);
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("vec%0d.stall", idx), 32'(stall), 32'(e.stall));
        chk($sformatf("vec%0d.if_hold", idx), 32'(if_hold), 32'(e.stall));
        chk($sformatf("vec%0d.if_flush", idx), 32'(if_flush), 32'(e.flush));
        chk($sformatf("vec%0d.fwd", idx), 32'(id_a_fwd_sel), 32'(e.fwd));
    endtask

    initial begin
        //          oc      rs1 rs2 cnd dcw exoc    exrd wen mmoc    mmrd wen  stall flush fwd
        tbl[0]  = '{RR_ALU, 3,  5,  0,  0,  LOAD,   3,   1,  NOFORW, 0,   0,   1, 0, FWDSEL_ID_A};
        tbl[1]  = '{RR_ALU, 5,  3,  0,  0,  LOAD,   3,   1,  NOFORW, 0,   0,   1, 0, FWDSEL_ID_A};
        tbl[2]  = '{IM_ALU, 1,  3,  0,  0,  LOAD,   3,   1,  NOFORW, 0,   0,   0, 0, FWDSEL_ID_A};
        tbl[3]  = '{RR_ALU, 0,  0,  0,  0,  LOAD,   0,   1,  NOFORW, 0,   0,   0, 0, FWDSEL_ID_A};
        tbl[4]  = '{BRANCH, 7,  0,  1,  0,  NOFORW, 0,   0,  RR_ALU, 7,   1,   0, 1, FWDSEL_EX_MEM_ALU_OUT};
        tbl[5]  = '{BRANCH, 7,  0,  1,  0,  RR_ALU, 7,   1,  NOFORW, 0,   0,   1, 0, FWDSEL_ID_A};
        tbl[6]  = '{BRANCH, 7,  0,  0,  0,  NOFORW, 0,   0,  LOAD,   7,   1,   1, 0, FWDSEL_ID_A};
        tbl[7]  = '{BRANCH, 7,  0,  1,  0,  NOFORW, 0,   0,  RR_ALU, 7,   0,   0, 1, FWDSEL_ID_A};
        tbl[8]  = '{NOFORW, 3,  3,  0,  0,  LOAD,   3,   1,  NOFORW, 0,   0,   0, 0, FWDSEL_ID_A};
        tbl[9]  = '{STORE,  1,  9,  0,  0,  LOAD,   9,   1,  NOFORW, 0,   0,   1, 0, FWDSEL_ID_A};
        tbl[10] = '{RR_ALU, 2,  4,  0,  0,  NOFORW, 0,   0,  RR_ALU, 2,   1,   0, 0, FWDSEL_EX_MEM_ALU_OUT};
        tbl[11] = '{BRANCH, 6,  0,  1,  1,  NOFORW, 0,   0,  NOFORW, 0,   0,   1, 0, FWDSEL_ID_A};
        tbl[12] = '{RR_ALU, 3,  5,  0,  0,  LOAD,   3,   0,  NOFORW, 0,   0,   0, 0, FWDSEL_ID_A};
        tbl[13] = '{RR_ALU, 0,  0,  0,  0,  NOFORW, 0,   0,  IM_ALU, 0,   1,   0, 0, FWDSEL_ID_A};

        // reset values, with inputs that would otherwise forward and flush
        idle();
        rst = 0;
        id_opcode_class = BRANCH; id_ir_rs1 = 7; id_cond = 1;
        ex_mem_opcode_class = RR_ALU; ex_mem_reg_rd = 7; ex_mem_reg_wen = 1;
        @(negedge clk); #1;
        chk("rst.stall", 32'(stall), 1);
        chk("rst.if_hold", 32'(if_hold), 1);
        chk("rst.if_flush", 32'(if_flush), 0);
        chk("rst.fwd", 32'(id_a_fwd_sel), 32'(FWDSEL_ID_A));
        chk("rst.halted", 32'(halted), 0);
        chk("rst.exception", 32'(exception), 0);
        chk("rst.stall_count", 32'(stall_count), 0);
        do_reset();

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check_out(i);
        end

        // load-use stalls exactly once; the load in EX/MEM is not forwarded
        do_reset();
        @(negedge clk);
        idle();
        id_opcode_class = RR_ALU; id_ir_rs1 = 3; id_ir_rs2 = 5;
        id_ex_opcode_class = LOAD; id_ex_reg_rd = 3; id_ex_reg_wen = 1;
        #1;
        chk("lu.stall", 32'(stall), 1);
        chk("lu.count0", 32'(stall_count), 0);
        @(negedge clk);
        id_ex_opcode_class = NOFORW; id_ex_reg_rd = 0; id_ex_reg_wen = 0;
        ex_mem_opcode_class = LOAD; ex_mem_reg_rd = 3; ex_mem_reg_wen = 1;
        #1;
        chk("lu.stall_clear", 32'(stall), 0);
        chk("lu.fwd", 32'(id_a_fwd_sel), 32'(FWDSEL_ID_A));
        chk("lu.count1", 32'(stall_count), 1);

        // trap: halted appears exactly 4 edges after the trap cycle
        do_reset();
        @(negedge clk);
        idle();
        id_halt = 1;
        #1;
        chk("trap.stall", 32'(stall), 1);
        chk("trap.if_hold", 32'(if_hold), 1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            idle();
            #1;
            chk($sformatf("trap.halted_e%0d", k), 32'(halted), (k >= 4) ? 1 : 0);
            chk($sformatf("trap.stall_e%0d", k), 32'(stall), 1);
        end
        chk("trap.exception", 32'(exception), 0);

        // trap with two frozen cycles mid-drain: halted delayed to edge 6
        do_reset();
        @(negedge clk);
        idle();
        id_halt = 1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            idle();
            dc_wait = (k == 2 || k == 3);
            #1;
            chk($sformatf("frz.halted_e%0d", k), 32'(halted), (k >= 6) ? 1 : 0);
        end

        // illegal wins over trap
        do_reset();
        @(negedge clk);
        idle();
        id_halt = 1; id_illegal_instr = 1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            idle();
            #1;
            chk($sformatf("exc.exception_e%0d", k), 32'(exception), (k >= 4) ? 1 : 0);
            chk($sformatf("exc.halted_e%0d", k), 32'(halted), 0);
        end

        // reset during EXC_DRAIN aborts it; RUN resumes after release
        do_reset();
        @(negedge clk);
        idle();
        id_illegal_instr = 1;
        @(negedge clk);
        idle();
        @(negedge clk);
        rst = 0;
        ex_mem_opcode_class = RR_ALU; ex_mem_reg_rd = 4; ex_mem_reg_wen = 1; id_ir_rs1 = 4;
        #1;
        chk("abort.stall", 32'(stall), 1);
        chk("abort.fwd", 32'(id_a_fwd_sel), 32'(FWDSEL_ID_A));
        chk("abort.exception", 32'(exception), 0);
        @(negedge clk);
        rst = 1;
        #1;
        chk("abort.run_stall", 32'(stall), 0);
        chk("abort.run_fwd", 32'(id_a_fwd_sel), 32'(FWDSEL_EX_MEM_ALU_OUT));
        repeat (4) @(negedge clk);
        #1;
        chk("abort.no_exception", 32'(exception), 0);
        chk("abort.running", 32'(stall), 0);

        // counter saturates at all-ones under a long dc_wait run
        do_reset();
        @(negedge clk);
        idle();
        dc_wait = 1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            #1;
            if (k == 14 || k == 15 || k == 20)
                chk($sformatf("sat.count_e%0d", k), 32'(stall_count), (k >= 15) ? 15 : k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
